line_scheduler: RTL and testbench
=================================

// Module: line_scheduler
// PURPOSE
//  Sequences line parameters (m, c) into the frame-overlay line drawer.
//  A requester (peak detector, host, or testbench) queues lines over a valid/ready
//  port. The scheduler presents one line per display slot and changes m/c only at
//  frame boundaries, so a line is never torn mid-frame.
//  It sits between the Hough peak stage and the overlay, sharing FrameIn with it.
// PARAMETERS
//  DEPTH         4   queued-line capacity; power of 2, 2..16
//  DWELL_FRAMES  1   frames each line is shown before advancing; 1..255
//  COORD_W       8   width of m, c (matches overlay pixel coordinates)
// PORTS
//  Clk        in   1               system clock, rising edge
//  nReset     in   1               asynchronous, active-low reset
//  FrameIn    in   1               frame-start pulse, same signal the overlay sees
//  ReqValid   in   1               requester presents a line
//  ReqReady   out  1               scheduler accepts; transfer when Valid&Ready
//  ReqM       in   COORD_W         gradient of the queued line
//  ReqC       in   COORD_W         intercept of the queued line
//  Flush      in   1               drop queue and current line
//  m          out  COORD_W         gradient to overlay (registered)
//  c          out  COORD_W         intercept to overlay (registered)
//  LineValid  out  1               m/c are live; top level gates overlay draw
//  Count      out  $clog2(DEPTH)+1 queue occupancy (registered)
// BEHAVIOUR
//  Reset: state=IDLE; m=0, c=0, LineValid=0, Count=0, ReqReady=1, dwell=0.
//   Reset mid-frame aborts everything; no partial state is retained.
//  ReqReady = !full & !Flush (combinational from registered Count).
//   Push when ReqValid&ReqReady; Count increments the following cycle.
//   ReqValid may drop without a transfer; ReqM/ReqC are sampled only on transfer.
//  FSM (advance evaluated only on cycles with FrameIn=1):
//   IDLE: FIFO empty -> stay IDLE. Otherwise pop into m/c, LineValid<=1,
//     dwell<=DWELL_FRAMES-1, go to SHOW.
//   SHOW: if dwell!=0 -> dwell<=dwell-1 and hold m/c.
//     Else if FIFO non-empty -> pop next into m/c, reload dwell, stay SHOW.
//     Else -> m<=0, c<=0, LineValid<=0, go to IDLE.
//  Latency: m/c/LineValid update on the edge sampling FrameIn=1 and are stable
//   from the next cycle until the next FrameIn edge. The overlay's first
//   coordinate compare after frame start sees the new values.
//  Push and pop in the same cycle: both occur; Count is unchanged. A push into an
//   empty FIFO on a FrameIn cycle is NOT popped that cycle; it becomes eligible
//   at the next FrameIn.
//  Full: ReqReady=0; requester must hold its line; nothing is dropped or overwritten.
//  Pointers wrap modulo DEPTH; Count ranges 0..DEPTH inclusive.
//  Flush (priority over FrameIn and push): on the edge it is sampled, FIFO
//   pointers and Count go to 0; m=c=0, LineValid=0, go to IDLE. Held Flush keeps
//   the block idle.
//  FrameIn held high for several cycles: each high cycle is a frame event.
//   Requirement: the upstream source pulses FrameIn for exactly 1 cycle.
// STRUCTURE
//  hough_pkg: COORD_W default; state encoding localparams (IDLE=1'b0, SHOW=1'b1).
//   The overlay and peak stages share this package.
//  Sub-module line_fifo: synchronous FIFO, width 2*COORD_W, DEPTH entries.
//   Ports: push, pop, din, dout, full, empty, count; show-ahead dout.
//  line_scheduler contains the FSM, the dwell counter, and the output registers only.
// TESTING
//  1 Reset: assert nReset=0 mid-run -> m=c=0, LineValid=0, Count=0,
//     ReqReady=1 immediately.
//  2 Push (m=2,c=5), then FrameIn -> next cycle m=2, c=5, LineValid=1, Count=0.
//     Next FrameIn with empty FIFO -> LineValid=0, m=c=0.
//  3 DWELL_FRAMES=3; push (1,0),(3,7); 7 FrameIn pulses -> (1,0) shown frames
//     1-3, (3,7) frames 4-6, idle at frame 7.
//  4 DEPTH=4: push 5 lines back-to-back -> ReqReady drops after the 4th, Count=4.
//     The 5th is held, then accepted on the first pop; FIFO order is preserved.
//  5 Push into an empty FIFO on the same cycle as FrameIn -> not shown that frame;
//     shown at the following FrameIn.
//  6 Flush while SHOW with Count=2, FrameIn in the same cycle -> IDLE, Count=0,
//     LineValid=0; ReqReady=0 while Flush is high.

Source files
------------

// File: rtl/hough_pkg.sv
// Types and defaults shared by the Hough peak, scheduler and overlay stages.
package hough_pkg;

   localparam int DEFAULT_COORD_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

endpackage

// File: rtl/line_fifo.sv
// Show-ahead synchronous FIFO holding queued (m, c) line pairs.
module line_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_pushEn;
   logic             w_popEn;

   assign full     = (r_count == CNT_W'(DEPTH));
   assign empty    = (r_count == '0);
   assign count    = r_count;
   assign dout     = r_mem[r_rdPtr];
   assign w_pushEn = push & ~full & ~clear;
   assign w_popEn  = pop & ~empty & ~clear;

   always_ff @(posedge Clk) begin
      if (w_pushEn) begin
         r_mem[r_wrPtr] <= din;
      end
   end

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (clear) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_pushEn) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_popEn) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_pushEn, w_popEn})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/line_scheduler.sv
// Queues overlay lines and swaps the live (m, c) pair only on frame boundaries
// so a line is never torn mid-frame.
module line_scheduler #(
   parameter int DEPTH        = 4,
   parameter int DWELL_FRAMES = 1,
   parameter int COORD_W      = hough_pkg::DEFAULT_COORD_W,
   localparam int CNT_W       = $clog2(DEPTH) + 1
) (
   input  logic               Clk,
   input  logic               nReset,
   input  logic               FrameIn,
   input  logic               ReqValid,
   output logic               ReqReady,
   input  logic [COORD_W-1:0] ReqM,
   input  logic [COORD_W-1:0] ReqC,
   input  logic               Flush,
   output logic [COORD_W-1:0] m,
   output logic [COORD_W-1:0] c,
   output logic               LineValid,
   output logic [CNT_W-1:0]   Count
);

   import hough_pkg::*;

   localparam logic [7:0] DWELL_RELOAD = 8'(DWELL_FRAMES - 1);

   state_t               r_state;
   logic [COORD_W-1:0]   r_m;
   logic [COORD_W-1:0]   r_c;
   logic                 r_lineValid;
   logic [7:0]           r_dwell;

   logic [2*COORD_W-1:0] w_head;
   logic [COORD_W-1:0]   w_headM;
   logic [COORD_W-1:0]   w_headC;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;

   assign ReqReady  = ~w_full & ~Flush;
   assign w_push    = ReqValid & ReqReady;
   assign w_headM   = w_head[2*COORD_W-1:COORD_W];
   assign w_headC   = w_head[COORD_W-1:0];
   assign m         = r_m;
   assign c         = r_c;
   assign LineValid = r_lineValid;

   // Emptiness is judged before this cycle's push, so a line arriving on a
   // frame pulse waits for the next frame.
   assign w_pop = FrameIn & ~Flush & ~w_empty &
                  ((r_state == IDLE) | (r_dwell == 8'd0));

   line_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * COORD_W)
   ) u_fifo (
      .Clk    (Clk),
      .nReset (nReset),
      .clear  (Flush),
      .push   (w_push),
      .pop    (w_pop),
      .din    ({ReqM, ReqC}),
      .dout   (w_head),
      .full   (w_full),
      .empty  (w_empty),
      .count  (Count)
   );

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_state     <= IDLE;
         r_m         <= '0;
         r_c         <= '0;
         r_lineValid <= 1'b0;
         r_dwell     <= '0;
      end else if (Flush) begin
         r_state     <= IDLE;
         r_m         <= '0;
         r_c         <= '0;
         r_lineValid <= 1'b0;
         r_dwell     <= '0;
      end else if (FrameIn) begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_m         <= w_headM;
                  r_c         <= w_headC;
                  r_lineValid <= 1'b1;
                  r_dwell     <= DWELL_RELOAD;
                  r_state     <= SHOW;
               end
            end
            SHOW: begin
               if (r_dwell != 8'd0) begin
                  r_dwell <= r_dwell - 8'd1;
               end else if (!w_empty) begin
                  r_m     <= w_headM;
                  r_c     <= w_headC;
                  r_dwell <= DWELL_RELOAD;
               end else begin
                  r_m         <= '0;
                  r_c         <= '0;
                  r_lineValid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_scheduler.sv
// Scoreboard bench: a frame-level line-queue model predicts the display
// after every clock; a separate monitor compares the DUT against it.
module tb_line_scheduler;

   localparam int DEPTH = 4;
   localparam int DWELL = 3;
   localparam int CW    = 8;
   localparam int CNTW  = $clog2(DEPTH) + 1;

   typedef struct {
      logic [CW-1:0] m;
      logic [CW-1:0] c;
      logic          v;
      int            cnt;
   } exp_t;

   logic            Clk;
   logic            nReset;
   logic            FrameIn;
   logic            ReqValid;
   logic            ReqReady;
   logic [CW-1:0]   ReqM;
   logic [CW-1:0]   ReqC;
   logic            Flush;
   logic [CW-1:0]   m;
   logic [CW-1:0]   c;
   logic            LineValid;
   logic [CNTW-1:0] Count;

   int checks = 0;
   int errors = 0;

   exp_t           expq[$];
   logic [2*CW-1:0] lineQ[$];
   logic [CW-1:0]  curM;
   logic [CW-1:0]  curC;
   logic           curValid;
   int             framesLeft;

   line_scheduler #(
      .DEPTH        (DEPTH),
      .DWELL_FRAMES (DWELL),
      .COORD_W      (CW)
   ) dut (
      .Clk       (Clk),
      .nReset    (nReset),
      .FrameIn   (FrameIn),
      .ReqValid  (ReqValid),
      .ReqReady  (ReqReady),
      .ReqM      (ReqM),
      .ReqC      (ReqC),
      .Flush     (Flush),
      .m         (m),
      .c         (c),
      .LineValid (LineValid),
      .Count     (Count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic clearModel();
      lineQ.delete();
      expq.delete();
      curM       = '0;
      curC       = '0;
      curValid   = 1'b0;
      framesLeft = 0;
   endtask

   // Compares the DUT against one scoreboard entry.
   task automatic checkOutput(input exp_t e);
      check("m", int'(m), int'(e.m));
      check("c", int'(c), int'(e.c));
      check("LineValid", int'(LineValid), int'(e.v));
      check("Count", int'(Count), e.cnt);
   endtask

   // Monitor: each entry describes the state right after a clock edge.
   initial begin
      forever begin
         @(posedge Clk);
         #1;
         if (nReset && expq.size() > 0) begin
            checkOutput(expq.pop_front());
         end
      end
   end

   // Drives one cycle of inputs, checks ReqReady and advances the model.
   task automatic applyStimulus(input logic v, input logic [CW-1:0] lm,
                                input logic [CW-1:0] lc, input logic f,
                                input logic fl, output logic accepted);
      logic mReady;
      @(posedge Clk);
      #2;
      ReqValid = v;
      ReqM     = lm;
      ReqC     = lc;
      FrameIn  = f;
      Flush    = fl;
      mReady   = (lineQ.size() < DEPTH) && !fl;
      accepted = v && mReady;
      #1;
      check("ReqReady", int'(ReqReady), int'(mReady));
      if (fl) begin
         lineQ.delete();
         curM       = '0;
         curC       = '0;
         curValid   = 1'b0;
         framesLeft = 0;
      end else begin
         if (f) begin
            if (curValid && framesLeft > 0) begin
               framesLeft--;
            end else if (lineQ.size() > 0) begin
               {curM, curC} = lineQ.pop_front();
               curValid     = 1'b1;
               framesLeft   = DWELL - 1;
            end else begin
               curM     = '0;
               curC     = '0;
               curValid = 1'b0;
            end
         end
         if (accepted) begin
            lineQ.push_back({lm, lc});
         end
      end
      expq.push_back('{curM, curC, curValid, lineQ.size()});
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, a);
      end
   endtask

   task automatic frame();
      logic a;
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, a);
      idle(2);
   endtask

   task automatic pushLine(input logic [CW-1:0] lm, input logic [CW-1:0] lc);
      logic a;
      a = 1'b0;
      for (int i = 0; i < 20 && !a; i++) begin
         applyStimulus(1'b1, lm, lc, 1'b0, 1'b0, a);
      end
      check("pushAccepted", int'(a), 1);
   endtask

   task automatic doReset();
      @(posedge Clk);
      #4;
      nReset   = 1'b0;
      ReqValid = 1'b0;
      FrameIn  = 1'b0;
      Flush    = 1'b0;
      clearModel();
      #1;
      check("rstM", int'(m), 0);
      check("rstC", int'(c), 0);
      check("rstLineValid", int'(LineValid), 0);
      check("rstCount", int'(Count), 0);
      check("rstReqReady", int'(ReqReady), 1);
      #12;
      nReset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic a;
      logic pend;
      logic [CW-1:0] pm;
      logic [CW-1:0] pc;
      nReset   = 1'b0;
      FrameIn  = 1'b0;
      ReqValid = 1'b0;
      ReqM     = '0;
      ReqC     = '0;
      Flush    = 1'b0;
      clearModel();
      #22 nReset = 1'b1;

      // Single line shown, then retired once its dwell is spent.
      pushLine(8'd2, 8'd5);
      idle(1);
      for (int i = 0; i < DWELL + 1; i++) frame();

      // Two lines, each held for DWELL frames, then idle.
      pushLine(8'd1, 8'd0);
      pushLine(8'd3, 8'd7);
      for (int i = 0; i < 2 * DWELL + 1; i++) frame();

      // Fill to DEPTH; the fifth line waits until a pop frees a slot.
      for (int i = 0; i < DEPTH; i++) pushLine(8'(10 + i), 8'(20 + i));
      applyStimulus(1'b1, 8'd99, 8'd88, 1'b0, 1'b0, a);
      check("fullReject", int'(a), 0);
      applyStimulus(1'b1, 8'd99, 8'd88, 1'b1, 1'b0, a);
      pushLine(8'd99, 8'd88);
      for (int i = 0; i < DEPTH * DWELL + 2; i++) frame();

      // Push on a frame pulse into an empty queue: shown only next frame.
      applyStimulus(1'b1, 8'd44, 8'd55, 1'b1, 1'b0, a);
      idle(2);
      frame();

      // Flush while showing with two queued, together with a frame pulse.
      pushLine(8'd6, 8'd6);
      pushLine(8'd7, 8'd7);
      applyStimulus(1'b1, 8'd8, 8'd8, 1'b1, 1'b1, a);
      applyStimulus(1'b1, 8'd8, 8'd8, 1'b0, 1'b1, a);
      idle(2);

      // Mid-run asynchronous reset with a line live.
      pushLine(8'd9, 8'd1);
      frame();
      doReset();

      // Randomized traffic; the requester holds an unaccepted line or drops it.
      pend = 1'b0;
      pm   = '0;
      pc   = '0;
      for (int i = 0; i < 600; i++) begin
         if (!pend && $urandom_range(0, 9) < 6) begin
            pend = 1'b1;
            pm   = 8'($urandom);
            pc   = 8'($urandom);
         end else if (pend && $urandom_range(0, 19) == 0) begin
            pend = 1'b0;
         end
         applyStimulus(pend, pm, pc, ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 59) == 0), a);
         if (a) pend = 1'b0;
      end
      idle(2);
      @(posedge Clk);
      #2;
      check("scoreboardDrained", expq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
